// File: rtl/sram_wr_ctrl.sv
// Write/read timing controller for the 96-bit external async SRAM array.
// Buffers write words in a small FIFO and sequences CE_n/WE_n/OE_n with programmable setup/pulse/hold.
module sram_wr_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int T_SETUP    = 1,
    parameter int T_PULSE    = 2,
    parameter int T_HOLD     = 1
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [18:0] wr_addr,
    input  logic [95:0] wr_data,
    input  logic        rd_req,
    input  logic [18:0] rd_addr,
    output logic        rd_busy,
    output logic        rd_valid,
    output logic [95:0] rd_data,
    output logic        idle,
    output logic [18:0] SRAM_ADDR,
    output logic [95:0] SRAM_DQ_O,
    output logic        SRAM_DQ_OE,
    input  logic [95:0] SRAM_DQ_I,
    output logic        SRAM_CE_n,
    output logic        SRAM_WE_n,
    output logic        SRAM_OE_n
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_W_SETUP = 3'd1;
    localparam logic [2:0] S_W_PULSE = 3'd2;
    localparam logic [2:0] S_W_HOLD  = 3'd3;
    localparam logic [2:0] S_R_SETUP = 3'd4;
    localparam logic [2:0] S_R_PULSE = 3'd5;
    localparam logic [2:0] S_R_DONE  = 3'd6;

    // Counter load values are "cycles - 1"; reads always get at least one setup cycle.
    localparam logic [3:0] SETUP_LD  = 4'(T_SETUP - 1);
    localparam logic [3:0] RSETUP_LD = (T_SETUP > 1) ? 4'(T_SETUP - 1) : 4'd0;
    localparam logic [3:0] PULSE_LD  = 4'(T_PULSE - 1);
    localparam logic [3:0] HOLD_LD   = 4'(T_HOLD - 1);

    logic [2:0]  state;
    logic [3:0]  cnt;
    logic [18:0] fifo_addr [FIFO_DEPTH];
    logic [95:0] fifo_data [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic        empty, full_nxt, push, pop;
    logic [18:0] rd_addr_q;

    assign empty = (wr_ptr == rd_ptr);
    assign push  = wr_valid & wr_ready;
    assign pop   = (state == S_IDLE) & !empty;
    assign idle  = empty & (state == S_IDLE) & !rd_busy;

    always_comb begin
        wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push};
        rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};
        full_nxt   = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                     (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_addr[wr_ptr[AW-1:0]] <= wr_addr;
            fifo_data[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // wr_ready is registered from the post-update occupancy so it is exact each cycle.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            wr_ready <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            wr_ready <= !full_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rd_busy   <= 1'b0;
            rd_addr_q <= '0;
        end else if (rd_req && !rd_busy) begin
            rd_busy   <= 1'b1;
            rd_addr_q <= rd_addr;
        end else if (state == S_R_PULSE && cnt == 4'd0) begin
            rd_busy   <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            SRAM_ADDR  <= '0;
            SRAM_DQ_O  <= '0;
            SRAM_DQ_OE <= 1'b0;
            SRAM_CE_n  <= 1'b1;
            SRAM_WE_n  <= 1'b1;
            SRAM_OE_n  <= 1'b1;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        SRAM_ADDR  <= fifo_addr[rd_ptr[AW-1:0]];
                        SRAM_DQ_O  <= fifo_data[rd_ptr[AW-1:0]];
                        SRAM_CE_n  <= 1'b0;
                        SRAM_DQ_OE <= 1'b1;
                        if (T_SETUP == 0) begin
                            state     <= S_W_PULSE;
                            SRAM_WE_n <= 1'b0;
                            cnt       <= PULSE_LD;
                        end else begin
                            state <= S_W_SETUP;
                            cnt   <= SETUP_LD;
                        end
                    end else if (rd_busy) begin
                        SRAM_ADDR <= rd_addr_q;
                        SRAM_CE_n <= 1'b0;
                        state     <= S_R_SETUP;
                        cnt       <= RSETUP_LD;
                    end
                end
                S_W_SETUP: begin
                    if (cnt == 4'd0) begin
                        state     <= S_W_PULSE;
                        SRAM_WE_n <= 1'b0;
                        cnt       <= PULSE_LD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_W_PULSE: begin
                    if (cnt == 4'd0) begin
                        SRAM_WE_n <= 1'b1;
                        if (T_HOLD == 0) begin
                            SRAM_CE_n  <= 1'b1;
                            SRAM_DQ_OE <= 1'b0;
                            state      <= S_IDLE;
                        end else begin
                            state <= S_W_HOLD;
                            cnt   <= HOLD_LD;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_W_HOLD: begin
                    if (cnt == 4'd0) begin
                        SRAM_CE_n  <= 1'b1;
                        SRAM_DQ_OE <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_R_SETUP: begin
                    if (cnt == 4'd0) begin
                        state     <= S_R_PULSE;
                        SRAM_OE_n <= 1'b0;
                        cnt       <= PULSE_LD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_R_PULSE: begin
                    // Capture on the last OE_n-low cycle, then release the bus.
                    if (cnt == 4'd0) begin
                        rd_data   <= SRAM_DQ_I;
                        rd_valid  <= 1'b1;
                        SRAM_OE_n <= 1'b1;
                        SRAM_CE_n <= 1'b1;
                        state     <= S_R_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_R_DONE: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_wr_ctrl.sv
// Scoreboard bench for sram_wr_ctrl: instance 0 uses default timing, instance 1 the minimum (0/1/0) timing.
// A monitor pops expected writes/reads and checks SRAM pin timing against an occupancy/memory reference model.
`timescale 1ns/1ps
module tb_sram_wr_ctrl;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [18:0] a;
        logic [95:0] d;
    } wrItem_t;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        rstnQ;
    logic [1:0]  wrValid, wrReady, rdReq, rdBusy, rdValid, idle, dqOe, ceN, weN, oeN;
    logic [18:0] wrAddr [2];
    logic [18:0] rdAddr [2];
    logic [18:0] sAddr  [2];
    logic [95:0] wrData [2];
    logic [95:0] rdData [2];
    logic [95:0] dqO    [2];
    logic [95:0] dqI    [2];
    logic [95:0] sram   [2][64];

    int          total = 0;
    int          bad   = 0;
    int          cycle = 0;
    bit          stalled;
    logic [18:0] pool [64];
    logic [95:0] refMem [int];
    wrItem_t     expWr [2][$];
    logic [95:0] expRd [2][$];
    logic [18:0] expRdAddr [2][$];
    int          wStart [2][$];
    wrItem_t     curW [2];
    bit          curValid [2];
    int          accCnt [2], stCnt [2], weCnt [2], ceCnt [2];
    logic [1:0]  prevCe, prevWe;

    always #5 CLK = ~CLK;

    sram_wr_ctrl #(.FIFO_DEPTH(DEPTH), .T_SETUP(1), .T_PULSE(2), .T_HOLD(1)) dut0 (
        .CLK(CLK), .RSTn(RSTn),
        .wr_valid(wrValid[0]), .wr_ready(wrReady[0]), .wr_addr(wrAddr[0]), .wr_data(wrData[0]),
        .rd_req(rdReq[0]), .rd_addr(rdAddr[0]), .rd_busy(rdBusy[0]), .rd_valid(rdValid[0]),
        .rd_data(rdData[0]), .idle(idle[0]), .SRAM_ADDR(sAddr[0]), .SRAM_DQ_O(dqO[0]),
        .SRAM_DQ_OE(dqOe[0]), .SRAM_DQ_I(dqI[0]), .SRAM_CE_n(ceN[0]), .SRAM_WE_n(weN[0]),
        .SRAM_OE_n(oeN[0])
    );

    sram_wr_ctrl #(.FIFO_DEPTH(DEPTH), .T_SETUP(0), .T_PULSE(1), .T_HOLD(0)) dut1 (
        .CLK(CLK), .RSTn(RSTn),
        .wr_valid(wrValid[1]), .wr_ready(wrReady[1]), .wr_addr(wrAddr[1]), .wr_data(wrData[1]),
        .rd_req(rdReq[1]), .rd_addr(rdAddr[1]), .rd_busy(rdBusy[1]), .rd_valid(rdValid[1]),
        .rd_data(rdData[1]), .idle(idle[1]), .SRAM_ADDR(sAddr[1]), .SRAM_DQ_O(dqO[1]),
        .SRAM_DQ_OE(dqOe[1]), .SRAM_DQ_I(dqI[1]), .SRAM_CE_n(ceN[1]), .SRAM_WE_n(weN[1]),
        .SRAM_OE_n(oeN[1])
    );

    // Behavioural SRAM: drives a junk pattern whenever the outputs are not enabled.
    assign dqI[0] = (!ceN[0] && !oeN[0]) ? sram[0][sAddr[0][5:0]] : {3{32'hDEAD_0BAD}};
    assign dqI[1] = (!ceN[1] && !oeN[1]) ? sram[1][sAddr[1][5:0]] : {3{32'hDEAD_0BAD}};

    always @(posedge CLK) begin
        for (int k = 0; k < 2; k++)
            if (!ceN[k] && !weN[k]) sram[k][sAddr[k][5:0]] <= dqO[k];
    end

    always @(posedge CLK) cycle <= cycle + 1;

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) rstnQ <= 1'b0;
        else       rstnQ <= 1'b1;
    end

    function automatic int setupOf(input int k); return (k == 0) ? 1 : 0; endfunction
    function automatic int pulseOf(input int k); return (k == 0) ? 2 : 1; endfunction
    function automatic int holdOf(input int k);  return (k == 0) ? 1 : 0; endfunction
    function automatic int keyOf(input int k, input logic [18:0] a); return k * (1 << 20) + int'(a); endfunction

    task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One write on instance k; caller and return point are both 2 ns after a rising edge.
    task automatic applyStimulus(input int k, input logic [18:0] a, input logic [95:0] d);
        int      n = 0;
        wrItem_t it;
        wrValid[k] = 1'b1;
        wrAddr[k]  = a;
        wrData[k]  = d;
        while (!wrReady[k] && n < 200) begin
            @(posedge CLK); #2;
            n++;
        end
        if (n > 0) stalled = 1'b1;
        checkOutput("wrAcceptTimeout", 96'(n < 200), 96'd1);
        if (n < 200) begin
            it.a = a;
            it.d = d;
            expWr[k].push_back(it);
            refMem[keyOf(k, a)] = d;
        end
        @(posedge CLK); #2;
        wrValid[k] = 1'b0;
    endtask

    task automatic waitIdle(input int k);
        int n = 0;
        while (idle[k] !== 1'b1 && n < 500) begin
            @(posedge CLK); #2;
            n++;
        end
        checkOutput("idleTimeout", 96'(n < 500), 96'd1);
    endtask

    task automatic readReq(input int k, input logic [18:0] a, input bit waitDone);
        rdReq[k]  = 1'b1;
        rdAddr[k] = a;
        expRd[k].push_back(refMem.exists(keyOf(k, a)) ? refMem[keyOf(k, a)] : 96'd0);
        expRdAddr[k].push_back(a);
        @(posedge CLK); #2;
        rdReq[k] = 1'b0;
        checkOutput("rdBusyAfterReq", 96'(rdBusy[k]), 96'd1);
        if (waitDone) waitIdle(k);
    endtask

    // Monitor: scoreboard pops plus pin-timing and FIFO-occupancy checks, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge CLK);
            for (int k = 0; k < 2; k++) begin
                if (!RSTn || !rstnQ) begin
                    expWr[k].delete(); expRd[k].delete(); expRdAddr[k].delete(); wStart[k].delete();
                    accCnt[k] = 0; stCnt[k] = 0; weCnt[k] = 0; ceCnt[k] = 0;
                    curValid[k] = 1'b0; prevCe[k] = 1'b1; prevWe[k] = 1'b1;
                end else begin
                    checkOutput("weOeOverlap", 96'(weN[k] | oeN[k]), 96'd1);
                    if (!ceN[k] && prevCe[k] && dqOe[k]) begin
                        stCnt[k]++;
                        wStart[k].push_back(cycle);
                    end
                    if (!ceN[k]) ceCnt[k] = prevCe[k] ? 1 : ceCnt[k] + 1;
                    if (!weN[k]) weCnt[k] = prevWe[k] ? 1 : weCnt[k] + 1;
                    if (!weN[k] && prevWe[k]) begin
                        checkOutput("weFallPosition", 96'(ceCnt[k]), 96'(setupOf(k) + 1));
                        if (expWr[k].size() == 0) checkOutput("unexpectedWrite", 96'd1, 96'd0);
                        else begin
                            curW[k] = expWr[k].pop_front();
                            curValid[k] = 1'b1;
                        end
                    end
                    if (curValid[k] && !ceN[k]) begin
                        checkOutput("wrAddr", 96'(sAddr[k]), 96'(curW[k].a));
                        checkOutput("wrData", dqO[k], curW[k].d);
                        checkOutput("wrDqOe", 96'(dqOe[k]), 96'd1);
                    end
                    if (weN[k] && !prevWe[k]) checkOutput("weLowCycles", 96'(weCnt[k]), 96'(pulseOf(k)));
                    if (ceN[k] && !prevCe[k] && curValid[k]) begin
                        checkOutput("ceLowCycles", 96'(ceCnt[k]), 96'(setupOf(k) + pulseOf(k) + holdOf(k)));
                        curValid[k] = 1'b0;
                    end
                    if (!oeN[k]) begin
                        checkOutput("rdDqOe", 96'(dqOe[k]), 96'd0);
                        checkOutput("rdCe", 96'(ceN[k]), 96'd0);
                        if (expRdAddr[k].size() == 0) checkOutput("unexpectedReadCycle", 96'd1, 96'd0);
                        else checkOutput("rdAddr", 96'(sAddr[k]), 96'(expRdAddr[k][0]));
                    end
                    if (rdValid[k]) begin
                        checkOutput("rdBusyAtValid", 96'(rdBusy[k]), 96'd0);
                        if (expRd[k].size() == 0) checkOutput("unexpectedRdValid", 96'd1, 96'd0);
                        else begin
                            checkOutput("rdData", rdData[k], expRd[k].pop_front());
                            void'(expRdAddr[k].pop_front());
                        end
                    end
                    checkOutput("wrReady", 96'(wrReady[k]), 96'((accCnt[k] - stCnt[k]) < DEPTH));
                    if (wrValid[k] && wrReady[k]) accCnt[k]++;
                    prevCe[k] = ceN[k];
                    prevWe[k] = weN[k];
                end
            end
        end
    end

    // Directed scenarios first, then a randomized mix on both instances.
    initial begin
        int n;
        int k;
        int idx;
        RSTn = 1'b0;
        wrValid = '0;
        rdReq = '0;
        for (int i = 0; i < 2; i++) begin
            wrAddr[i] = '0; wrData[i] = '0; rdAddr[i] = '0;
        end
        for (int i = 0; i < 64; i++) pool[i] = {13'($urandom()), 6'(i)};
        pool[5] = 19'h12345;

        #12;
        checkOutput("rstWrReady", 96'(wrReady[0]), 96'd0);
        checkOutput("rstIdle", 96'(idle[0]), 96'd1);
        checkOutput("rstRdBusy", 96'(rdBusy[0]), 96'd0);
        checkOutput("rstRdValid", 96'(rdValid[0]), 96'd0);
        checkOutput("rstRdData", rdData[0], 96'd0);
        checkOutput("rstAddr", 96'(sAddr[0]), 96'd0);
        checkOutput("rstDqO", dqO[0], 96'd0);
        checkOutput("rstStrobes", 96'({ceN[0], weN[0], oeN[0], dqOe[0]}), 96'b1110);
        @(posedge CLK); #2;
        RSTn = 1'b1;
        @(posedge CLK); #2;
        checkOutput("relWrReady", 96'(wrReady), 96'b11);
        checkOutput("relIdle", 96'(idle), 96'b11);

        $display("[TB] single write with default timing");
        applyStimulus(0, 19'h00005, {12{8'hA5}});
        waitIdle(0);

        $display("[TB] asynchronous reset during the write pulse");
        applyStimulus(0, pool[63], 96'h0123_4567_89AB_CDEF_0F1E_2D3C);
        n = 0;
        while (weN[0] !== 1'b0 && n < 50) begin
            @(posedge CLK); #2;
            n++;
        end
        checkOutput("weLowTimeout", 96'(n < 50), 96'd1);
        #1 RSTn = 1'b0;
        #1;
        checkOutput("asyncRstStrobes", 96'({ceN[0], weN[0], dqOe[0]}), 96'b110);
        checkOutput("asyncRstAddr", 96'(sAddr[0]), 96'd0);
        @(posedge CLK); #2;
        RSTn = 1'b1;
        @(posedge CLK); #2;
        checkOutput("postRstWrReady", 96'(wrReady[0]), 96'd1);
        checkOutput("postRstIdle", 96'(idle[0]), 96'd1);

        $display("[TB] back-to-back fill");
        wStart[0].delete();
        stalled = 1'b0;
        for (int i = 0; i < 6; i++) applyStimulus(0, pool[i + 1], {$urandom(), $urandom(), $urandom()});
        waitIdle(0);
        checkOutput("fillStalled", 96'(stalled), 96'd1);
        checkOutput("fillStarts", 96'(wStart[0].size()), 96'd6);
        for (int i = 1; i < wStart[0].size(); i++)
            checkOutput("fillPeriod", 96'(wStart[0][i] - wStart[0][i - 1]), 96'd5);

        $display("[TB] write then read back");
        applyStimulus(0, 19'h12345, 96'hDEADBEEF_00C0FFEE_55AA55AA);
        readReq(0, 19'h12345, 1'b1);

        $display("[TB] writes take priority over a pending read");
        applyStimulus(0, pool[10], {$urandom(), $urandom(), $urandom()});
        applyStimulus(0, pool[10], {$urandom(), $urandom(), $urandom()});
        readReq(0, pool[10], 1'b0);
        rdReq[0] = 1'b1;
        rdAddr[0] = pool[20];
        @(posedge CLK); #2;
        rdReq[0] = 1'b0;
        waitIdle(0);

        $display("[TB] minimum timing instance");
        wStart[1].delete();
        for (int i = 0; i < 3; i++) applyStimulus(1, pool[i + 30], {$urandom(), $urandom(), $urandom()});
        waitIdle(1);
        checkOutput("fastStarts", 96'(wStart[1].size()), 96'd3);
        for (int i = 1; i < wStart[1].size(); i++)
            checkOutput("fastPeriod", 96'(wStart[1][i] - wStart[1][i - 1]), 96'd2);
        readReq(1, pool[31], 1'b1);

        $display("[TB] randomized traffic");
        for (int it = 0; it < 80; it++) begin
            k = int'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                n = int'($urandom_range(1, 5));
                for (int j = 0; j < n; j++)
                    applyStimulus(k, pool[$urandom_range(0, 62)], {$urandom(), $urandom(), $urandom()});
            end else begin
                idx = int'($urandom_range(0, 62));
                if (refMem.exists(keyOf(k, pool[idx]))) readReq(k, pool[idx], 1'b1);
            end
            n = int'($urandom_range(0, 3));
            repeat (n) begin
                @(posedge CLK); #2;
            end
        end
        waitIdle(0);
        waitIdle(1);
        repeat (2) @(posedge CLK);
        #2;
        checkOutput("wrQueueDrained", 96'(expWr[0].size() + expWr[1].size()), 96'd0);
        checkOutput("rdQueueDrained", 96'(expRd[0].size() + expRd[1].size()), 96'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
